// File: rtl/fifo_flush_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flush_pkg
// Description : Shared types and constants for the nibble-FIFO flush reader.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_flush_pkg;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 32;

    // Nibble value reserved by the FIFO to pad unused slots of a flush word
    localparam logic [NIB_W-1:0] PAD_NIBBLE = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_ACK     = 3'd5
    } state_t;

    function automatic logic is_pad(input logic [NIB_W-1:0] nib);
        return nib == PAD_NIBBLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flush_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : flush_word_unpacker
// Description : Captures a flush word, counts the nibbles below the first pad
//               and streams them LSB-first over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module flush_word_unpacker
    import fifo_flush_pkg::*;
#(
    parameter int NIBS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic                   enable,
    input  logic [NIBS*NIB_W-1:0]  word,
    input  logic                   ready,
    output logic                   valid,
    output logic [NIB_W-1:0]       data,
    output logic                   last,
    output logic                   load_empty,
    output logic                   handshake
);

    localparam int CNT_W = $clog2(NIBS + 1);

    logic [NIBS*NIB_W-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_load_cnt;
    logic                  w_found;

    // Number of nibbles from the LSB up to (not including) the first pad
    always_comb begin
        w_load_cnt = CNT_W'(NIBS);
        w_found    = 1'b0;
        for (int i = 0; i < NIBS; i++) begin
            if (!w_found && is_pad(word[i*NIB_W +: NIB_W])) begin
                w_load_cnt = CNT_W'(i);
                w_found    = 1'b1;
            end
        end
    end

    assign load_empty = (w_load_cnt == '0);
    assign valid      = enable;
    assign handshake  = enable & ready;
    assign last       = enable && (r_cnt == CNT_W'(1));
    // Output is zeroed outside DRAIN so idle outputs read as 0
    assign data       = enable ? r_shift[NIB_W-1:0] : '0;

    // Capture on load; shift out one nibble per accepted handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_shift <= word;
            r_cnt   <= w_load_cnt;
        end else if (handshake) begin
            r_shift <= r_shift >> NIB_W;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_flush_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flush_reader
// Description : Consumer end of the nibble-FIFO flush interface. Requests a
//               flush, captures the returned word, strips 0xC padding and
//               streams the valid nibbles LSB-first.
//               Optional statistics counters: FIFO_FLUSH_READER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_flush_reader
    import fifo_flush_pkg::*;
#(
    parameter int CAP_DELAY = 2,
    parameter int NIBS      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  start_nack_o,
    output logic                  fifo_flush_o,
    output logic                  fifo_rd_valid_o,
    input  logic [NIBS*NIB_W-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    output logic                  nib_valid_o,
    input  logic                  nib_ready_i,
    output logic [NIB_W-1:0]      nib_data_o,
    output logic                  nib_last_o
`ifdef FIFO_FLUSH_READER_STATS_EN
    ,
    output logic [15:0]           stat_flushes_o,
    output logic [15:0]           stat_nibbles_o,
    input  logic                  stat_clr_i
`endif
);

    // Wait counter holds CAP_DELAY-1 at most
    localparam int WAIT_W = (CAP_DELAY > 1) ? $clog2(CAP_DELAY) : 1;

    state_t            r_state;
    state_t            w_state_nx;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nx;
    logic              r_nack;
    logic              w_nack;
    logic              w_load;
    logic              w_enable;
    logic              w_load_empty;
    logic              w_handshake;

    // State, wait counter and refusal pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_nack     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_wait_cnt <= w_wait_nx;
            r_nack     <= w_nack;
        end
    end

    // Next-state logic and state-decoded controls
    always_comb begin
        w_state_nx = r_state;
        w_wait_nx  = r_wait_cnt;
        w_nack     = 1'b0;
        w_load     = 1'b0;
        w_enable   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (fifo_empty_i) begin
                        w_nack = 1'b1;
                    end else begin
                        w_state_nx = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                w_wait_nx  = WAIT_W'(CAP_DELAY - 1);
                // A one-cycle capture delay has no WAIT phase at all
                w_state_nx = (CAP_DELAY > 1) ? ST_WAIT : ST_CAPTURE;
            end
            ST_WAIT: begin
                w_wait_nx = r_wait_cnt - WAIT_W'(1);
                if (r_wait_cnt <= WAIT_W'(1)) begin
                    w_state_nx = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_load     = 1'b1;
                w_state_nx = w_load_empty ? ST_ACK : ST_DRAIN;
            end
            ST_DRAIN: begin
                w_enable = 1'b1;
                if (w_handshake && nib_last_o) begin
                    w_state_nx = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign busy_o          = (r_state != ST_IDLE);
    assign start_nack_o    = r_nack;
    assign fifo_flush_o    = (r_state == ST_REQ) || (r_state == ST_WAIT) ||
                             (r_state == ST_CAPTURE);
    assign fifo_rd_valid_o = (r_state == ST_ACK);

    flush_word_unpacker #(
        .NIBS (NIBS)
    ) u_unpacker (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .enable     (w_enable),
        .word       (fifo_rd_data_i),
        .ready      (nib_ready_i),
        .valid      (nib_valid_o),
        .data       (nib_data_o),
        .last       (nib_last_o),
        .load_empty (w_load_empty),
        .handshake  (w_handshake)
    );

`ifdef FIFO_FLUSH_READER_STATS_EN
    logic [15:0] r_stat_flushes;
    logic [15:0] r_stat_nibbles;

    // Free-running wrap-around counters of completed flushes and nibbles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_flushes <= '0;
            r_stat_nibbles <= '0;
        end else if (stat_clr_i) begin
            r_stat_flushes <= '0;
            r_stat_nibbles <= '0;
        end else begin
            if (fifo_rd_valid_o) begin
                r_stat_flushes <= r_stat_flushes + 16'd1;
            end
            if (w_handshake) begin
                r_stat_nibbles <= r_stat_nibbles + 16'd1;
            end
        end
    end

    assign stat_flushes_o = r_stat_flushes;
    assign stat_nibbles_o = r_stat_nibbles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_flush_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_flush_reader
// Description : Self-checking bench for fifo_flush_reader with a queue-based
//               reference model of the flush transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_flush_reader;

    localparam int CAPD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        busy_o;
    logic        start_nack_o;
    logic        fifo_flush_o;
    logic        fifo_rd_valid_o;
    logic [31:0] fifo_rd_data_i;
    logic        fifo_empty_i;
    logic        nib_valid_o;
    logic        nib_ready_i;
    logic [3:0]  nib_data_o;
    logic        nib_last_o;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_flush_reader #(
        .CAP_DELAY (CAPD),
        .NIBS      (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .busy_o          (busy_o),
        .start_nack_o    (start_nack_o),
        .fifo_flush_o    (fifo_flush_o),
        .fifo_rd_valid_o (fifo_rd_valid_o),
        .fifo_rd_data_i  (fifo_rd_data_i),
        .fifo_empty_i    (fifo_empty_i),
        .nib_valid_o     (nib_valid_o),
        .nib_ready_i     (nib_ready_i),
        .nib_data_o      (nib_data_o),
        .nib_last_o      (nib_last_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One flush transaction. Cycle 0 is the cycle start_i is presented in IDLE.
    // mode 0: ready always 1; 1: random ready and stray starts; 2: 3-cycle stall
    // on the second nibble.
    task automatic run_flush(input logic [31:0] word, input int mode);
        logic [3:0] exp_q[$];
        bit         stop;
        bit         exp_valid;
        int         idx, t, ack_t, stall;
        exp_q = {};
        stop  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!stop && word[i*4 +: 4] == 4'hC) stop = 1'b1;
            if (!stop) exp_q.push_back(word[i*4 +: 4]);
        end
        fifo_empty_i   = 1'b0;
        fifo_rd_data_i = word;
        start_i        = 1'b1;
        nib_ready_i    = 1'b0;
        check("busy_before", busy_o, 0);
        // All-pad word acknowledges in the cycle after CAPTURE
        ack_t = (exp_q.size() == 0) ? CAPD + 2 : -1;
        idx   = 0;
        stall = 0;
        t     = 0;
        stop  = 1'b0;
        while (!stop) begin
            tick();
            t++;
            start_i = (mode == 1 && ack_t < 0) ? 1'($urandom % 2) : 1'b0;
            case (mode)
                1:       nib_ready_i = 1'($urandom % 2);
                2: begin
                    if (idx == 1 && stall < 3) begin
                        nib_ready_i = 1'b0;
                        stall++;
                    end else begin
                        nib_ready_i = 1'b1;
                    end
                end
                default: nib_ready_i = 1'b1;
            endcase
            check("flush", fifo_flush_o, 32'(t <= CAPD + 1));
            check("busy", busy_o, 32'(ack_t < 0 || t <= ack_t));
            check("ack", fifo_rd_valid_o, 32'(t == ack_t));
            check("nack", start_nack_o, 0);
            exp_valid = (t >= CAPD + 2) && (idx < exp_q.size());
            check("valid", nib_valid_o, 32'(exp_valid));
            if (exp_valid) begin
                check("data", nib_data_o, exp_q[idx]);
                check("last", nib_last_o, 32'(idx == exp_q.size() - 1));
                if (nib_ready_i) begin
                    idx++;
                    if (idx == exp_q.size()) ack_t = t + 1;
                end
            end
            if (ack_t >= 0 && t > ack_t) stop = 1'b1;
            if (t > 300) begin
                check("timeout", 1, 0);
                stop = 1'b1;
            end
        end
        nib_ready_i = 1'b0;
    endtask

    task automatic run_nack();
        fifo_empty_i = 1'b1;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        check("nack_pulse", start_nack_o, 1);
        check("nack_flush", fifo_flush_o, 0);
        check("nack_busy", busy_o, 0);
        tick();
        check("nack_end", start_nack_o, 0);
        check("nack_busy2", busy_o, 0);
        fifo_empty_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int i = 0; i < 8; i++) begin
            w[i*4 +: 4] = ($urandom % 4 == 0) ? 4'hC : 4'($urandom % 16);
        end
        return w;
    endfunction

    initial begin
        reset          = 1'b0;
        start_i        = 1'b0;
        fifo_rd_data_i = '0;
        fifo_empty_i   = 1'b0;
        nib_ready_i    = 1'b0;
        tick();
        tick();
        check("rst_busy", busy_o, 0);
        check("rst_flush", fifo_flush_o, 0);
        check("rst_ack", fifo_rd_valid_o, 0);
        check("rst_valid", nib_valid_o, 0);
        check("rst_data", nib_data_o, 0);
        check("rst_last", nib_last_o, 0);
        check("rst_nack", start_nack_o, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        run_flush(32'hCCCC4321, 0);
        run_flush(32'h87654321, 0);
        run_flush(32'hCCCCCCCC, 0);
        run_nack();
        run_flush(32'hCCCCC5A3, 2);
        run_flush(32'hC7654321, 1);

        // Asynchronous reset while a nibble is pending in DRAIN
        fifo_rd_data_i = 32'h87654321;
        start_i        = 1'b1;
        nib_ready_i    = 1'b0;
        for (int i = 0; i < CAPD + 2; i++) begin
            tick();
            start_i = 1'b0;
        end
        check("pre_rst_valid", nib_valid_o, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", nib_valid_o, 0);
        check("arst_flush", fifo_flush_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_ack", fifo_rd_valid_o, 0);
        check("arst_data", nib_data_o, 0);
        check("arst_last", nib_last_o, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        run_flush(32'hCC00FED1, 0);

        for (int k = 0; k < 25; k++) begin
            if ($urandom % 6 == 0) run_nack();
            run_flush(rand_word(), int'($urandom % 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
